// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and constants for the dual-port memory
package memory_pkg;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/memory_dp_if.sv
// rtl/memory_dp_if.sv - write, read and clear signals of the dual-port memory
interface memory_dp_if #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 64
);
    localparam int LOGSIZE = $clog2(SIZE);

    logic               wr_en;
    logic [LOGSIZE-1:0] wr_addr;
    logic [WIDTH-1:0]   data_in;
    logic               rd_en;
    logic [LOGSIZE-1:0] rd_addr;
    logic [WIDTH-1:0]   data_out;
    logic               rd_valid;
    logic               clr_start;
    logic               clr_busy;

    modport master (
        output wr_en, wr_addr, data_in, rd_en, rd_addr, clr_start,
        input  data_out, rd_valid, clr_busy
    );

    modport slave (
        input  wr_en, wr_addr, data_in, rd_en, rd_addr, clr_start,
        output data_out, rd_valid, clr_busy
    );

endinterface

// File: rtl/memory_rd_pipe.sv
// rtl/memory_rd_pipe.sv - read data/valid delay line, one or two register stages
module memory_rd_pipe #(
    parameter int WIDTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);

    if (RD_LAT == 2) begin : g_two
        logic             v1;
        logic [WIDTH-1:0] d1;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v1 <= 1'b0;
                d1 <= '0;
            end else begin
                v1 <= valid_in;
                if (valid_in) d1 <= data_in;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_out <= 1'b0;
                data_out  <= '0;
            end else begin
                valid_out <= v1;
                if (v1) data_out <= d1;
            end
        end
    end else begin : g_one
        // Data only moves with a valid read so data_out holds between results
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_out <= 1'b0;
                data_out  <= '0;
            end else begin
                valid_out <= valid_in;
                if (valid_in) data_out <= data_in;
            end
        end
    end

endmodule

// File: rtl/memory_dp.sv
// rtl/memory_dp.sv - 1W/1R memory with read pipeline, collision mux and clear sweep
module memory_dp
    import memory_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SIZE     = 64,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = RDW_OLD
) (
    input  logic clk,
    input  logic reset,
    memory_dp_if.slave bus
);
    localparam int LOGSIZE = $clog2(SIZE);
    localparam logic [LOGSIZE:0]   SIZE_L = (LOGSIZE+1)'(SIZE);
    localparam logic [LOGSIZE-1:0] LAST   = LOGSIZE'(SIZE - 1);

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_lat_check
        $error("memory_dp: RD_LAT must be 1 or 2");
    end

    logic [WIDTH-1:0]   mem [SIZE];
    clr_state_t         state, state_nxt;
    logic [LOGSIZE-1:0] clr_cnt, clr_cnt_nxt;
    logic               idle, wr_ok, rd_ok, rd_in_range, collide;
    logic [WIDTH-1:0]   rd_word;

    // External ports are locked out for the whole sweep
    assign idle        = (state == CLR_IDLE);
    assign wr_ok       = idle && bus.wr_en && ({1'b0, bus.wr_addr} < SIZE_L);
    assign rd_ok       = idle && bus.rd_en;
    assign rd_in_range = ({1'b0, bus.rd_addr} < SIZE_L);
    assign collide     = wr_ok && (bus.wr_addr == bus.rd_addr);
    assign bus.clr_busy = (state == CLR_RUN);

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (RDW_MODE == RDW_NEW && collide) rd_word = bus.data_in;
            else                                rd_word = mem[bus.rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLR_RUN)  mem[clr_cnt]     <= '0;
        else if (wr_ok)        mem[bus.wr_addr] <= bus.data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLR_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            CLR_IDLE: begin
                if (bus.clr_start) begin
                    state_nxt   = CLR_RUN;
                    clr_cnt_nxt = '0;
                end
            end
            CLR_RUN: begin
                if (clr_cnt == LAST) begin
                    state_nxt   = CLR_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + LOGSIZE'(1);
                end
            end
            default: state_nxt = CLR_IDLE;
        endcase
    end

    memory_rd_pipe #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_rd_pipe (
        .clk      (clk),
        .reset    (reset),
        .valid_in (rd_ok),
        .data_in  (rd_word),
        .data_out (bus.data_out),
        .valid_out(bus.rd_valid)
    );

endmodule

// File: tb/tb_memory_dp.sv
// tb/tb_memory_dp.sv - three configurations driven in lockstep against a behavioural model
module tb_memory_dp;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        wr_en = 1'b0, rd_en = 1'b0, clr_start = 1'b0;
    logic [5:0]  wr_addr = '0, rd_addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] dout [3];
    logic        vld  [3];
    logic        bsy  [3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // dut0: 64 words, latency 1, old data; dut1: 64 words, latency 2, new data; dut2: 48 words
    for (genvar g = 0; g < 3; g++) begin : g_dut
        memory_dp_if #(.WIDTH(16), .SIZE(g == 2 ? 48 : 64)) bus ();
        assign bus.wr_en     = wr_en;
        assign bus.wr_addr   = wr_addr;
        assign bus.data_in   = data_in;
        assign bus.rd_en     = rd_en;
        assign bus.rd_addr   = rd_addr;
        assign bus.clr_start = clr_start;
        assign dout[g] = bus.data_out;
        assign vld[g]  = bus.rd_valid;
        assign bsy[g]  = bus.clr_busy;
        memory_dp #(
            .WIDTH(16), .SIZE(g == 2 ? 48 : 64),
            .RD_LAT(g == 1 ? 2 : 1), .RDW_MODE(g == 1 ? 1 : 0)
        ) dut (
            .clk(clk), .reset(reset), .bus(bus)
        );
    end

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    int          size_m [3] = '{64, 64, 48};
    int          lat_m  [3] = '{1, 2, 1};
    int          rdw_m  [3] = '{0, 1, 0};
    logic [15:0] mmem   [3][64];
    exp_t        expq   [3][$];
    logic [15:0] held   [3] = '{16'h0, 16'h0, 16'h0};
    int          clr_cyc[3] = '{0, 0, 0};
    bit          clr_act[3] = '{0, 0, 0};

    function automatic bit busy_at(int d, int c);
        return clr_act[d] && (c >= clr_cyc[d] + 1) && (c <= clr_cyc[d] + size_m[d]);
    endfunction

    task automatic cycle(bit we, int wa, logic [15:0] wd, bit re, int ra, bit cs);
        exp_t e;
        @(posedge clk); #1;
        wr_en = we; wr_addr = 6'(wa); data_in = wd;
        rd_en = re; rd_addr = 6'(ra); clr_start = cs;
        for (int d = 0; d < 3; d++) begin
            if (!busy_at(d, cyc)) begin
                if (re) begin
                    e.due = cyc + lat_m[d];
                    if (ra >= size_m[d])                     e.data = 16'h0;
                    else if (rdw_m[d] == 1 && we && wa == ra) e.data = wd;
                    else                                     e.data = mmem[d][ra];
                    expq[d].push_back(e);
                end
                if (we && wa < size_m[d]) mmem[d][wa] = wd;
                if (cs) begin
                    clr_act[d] = 1'b1;
                    clr_cyc[d] = cyc;
                    for (int i = 0; i < 64; i++) mmem[d][i] = 16'h0;
                end
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) cycle(0, 0, 16'h0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            expq[d].delete();
            held[d] = 16'h0;
            clr_act[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bsy[d] !== 1'b0 || vld[d] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset dut%0d: busy=%b valid=%b want 0 0", d, bsy[d], vld[d]);
            end
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bsy[d] !== busy_at(d, cyc)) begin
                errors++;
                $display("FAIL clr_busy dut%0d cyc %0d: got %b want %b", d, cyc, bsy[d], busy_at(d, cyc));
            end
            while (expq[d].size() > 0 && expq[d][0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_rd_valid dut%0d cyc %0d: got none want data %h due %0d",
                         d, cyc, expq[d][0].data, expq[d][0].due);
                void'(expq[d].pop_front());
            end
            checks++;
            if (vld[d] === 1'b1) begin
                if (expq[d].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rd_valid dut%0d cyc %0d: got data %h want no valid", d, cyc, dout[d]);
                end else begin
                    e = expq[d].pop_front();
                    held[d] = e.data;
                    if (e.due != cyc || dout[d] !== e.data) begin
                        errors++;
                        $display("FAIL read dut%0d cyc %0d: got %h want %h at cyc %0d", d, cyc, dout[d], e.data, e.due);
                    end
                end
            end else if (vld[d] !== 1'b0 || dout[d] !== held[d]) begin
                errors++;
                $display("FAIL hold dut%0d cyc %0d: got valid=%b data=%h want 0 %h", d, cyc, vld[d], dout[d], held[d]);
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 64; i++) mmem[d][i] = 16'h0;

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (dout[d] !== 16'h0 || vld[d] !== 1'b0 || bsy[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %h %b %b want 0000 0 0", d, dout[d], vld[d], bsy[d]);
            end
        end
        reset = 1'b0;

        // initial sweep with a write and read mid-sweep that must be ignored
        cycle(0, 0, 16'h0, 0, 0, 1);
        idle(20);
        cycle(1, 10, 16'hDEAD, 1, 10, 0);
        idle(50);
        cycle(0, 0, 16'h0, 1, 10, 0);

        cycle(1, 5, 16'h1234, 0, 0, 0);
        cycle(0, 0, 16'h0, 1, 5, 0);
        idle(3);

        cycle(1, 0, 16'h000A, 0, 0, 0);
        cycle(1, 1, 16'h000B, 0, 0, 0);
        cycle(1, 2, 16'h000C, 0, 0, 0);
        cycle(0, 0, 16'h0, 1, 0, 0);
        cycle(0, 0, 16'h0, 1, 1, 0);
        cycle(0, 0, 16'h0, 1, 2, 0);
        idle(3);

        cycle(1, 7, 16'h0001, 0, 0, 0);
        cycle(1, 7, 16'hBEEF, 1, 7, 0);
        cycle(0, 0, 16'h0, 1, 7, 0);
        idle(3);

        cycle(1, 50, 16'h5050, 0, 0, 0);
        cycle(1, 47, 16'h4747, 1, 50, 0);
        cycle(0, 0, 16'h0, 1, 47, 0);
        cycle(0, 0, 16'h0, 1, 50, 0);
        idle(3);

        for (int n = 0; n < 600; n++)
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 63), 16'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 99) == 0);
        idle(70);

        for (int i = 0; i < 64; i++) cycle(1, i, 16'($urandom), 0, 0, 0);
        cycle(0, 0, 16'h0, 0, 0, 1);
        idle(30);
        cycle(1, 3, 16'hFFFF, 1, 3, 0);
        idle(40);
        for (int i = 0; i < 64; i++) cycle(0, 0, 16'h0, 1, i, 0);
        idle(3);

        for (int i = 0; i < 8; i++) cycle(1, i, 16'h1111 * 16'(i + 1), 0, 0, 0);
        cycle(0, 0, 16'h0, 0, 0, 1);
        idle(20);
        do_reset();
        cycle(0, 0, 16'h0, 0, 0, 1);
        idle(66);
        for (int i = 0; i < 8; i++) cycle(0, 0, 16'h0, 1, i, 0);
        idle(5);

        for (int d = 0; d < 3; d++) begin
            checks++;
            if (expq[d].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d: got %0d outstanding reads want 0", d, expq[d].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
